// File: rtl/mnk_game_engine.sv
// mnk_game_engine: two-player m,n,k game engine on an N x N board with K-in-a-row wins.
//
// Players A and B offer moves over a valid/ready handshake. Illegal moves are rejected
// with a one-cycle move_err pulse. A legal move is written at the transfer edge. The
// engine then spends four cycles scanning row, column, diagonal and anti-diagonal
// through the placed cell. It then reports a win or a draw, or hands the turn over.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, first_player  synchronous new-game request and the player who moves first
//   move_valid/pos/player  offered move (pos = row*N+col, player 1 = A, 0 = B)
//   move_ready           engine can accept a move
//   move_ack, move_err   one-cycle pulses: legal move checked / offered move rejected
//   turn                 player expected next (1 = A)
//   board_flat           cell i at [2i+1:2i]; 10 = empty, 01 = A, 00 = B
//   move_count           legal moves placed
//   game_over, winner, draw  game status (winner 10 = none, 01 = A, 00 = B)
module mnk_game_engine #(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int POS_W = $clog2(N * N)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        first_player,
  input  logic                        move_valid,
  input  logic [POS_W-1:0]            move_pos,
  input  logic                        move_player,
  output logic                        move_ready,
  output logic                        move_ack,
  output logic                        move_err,
  output logic                        turn,
  output logic [2*N*N-1:0]            board_flat,
  output logic [$clog2(N*N+1)-1:0]    move_count,
  output logic                        game_over,
  output logic [1:0]                  winner,
  output logic                        draw
);

  localparam int CELLS = N * N;
  localparam int CNT_W = $clog2(CELLS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] CELL_EMPTY = 2'b10;
  localparam logic [1:0] CELL_A     = 2'b01;
  localparam logic [1:0] CELL_B     = 2'b00;

  if (N < 3 || N > 8 || K < 2 || K > N) begin : g_param_err
    $error("mnk_game_engine: N must be 3..8 and K must satisfy 2 <= K <= N");
  end

  logic [1:0]         state_q, state_d;
  logic [2*N*N-1:0]   board_q, board_d;
  logic               turn_q, turn_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         winner_q, winner_d;
  logic               draw_q, draw_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [1:0]         dir_q, dir_d;
  logic               win_q, win_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  // During CHECK the mover is the player whose turn it is; turn only toggles on exit.
  logic [1:0] mover_code;
  assign mover_code = turn_q ? CELL_A : CELL_B;

  // Length of the mover's contiguous run through pos_q along direction dir_q.
  int run_len;
  always_comb begin
    int r0, c0, dr, dc, rr, cc, step;
    logic go;
    r0      = int'(pos_q) / N;
    c0      = int'(pos_q) % N;
    rr      = 0;
    cc      = 0;
    step    = 0;
    go      = 1'b0;
    run_len = 1;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int s = 0; s < 2; s++) begin
      go = 1'b1;
      for (int i = 1; i < K; i++) begin
        step = (s == 0) ? i : -i;
        rr   = r0 + step * dr;
        cc   = c0 + step * dc;
        // Bounds checked per axis so a run never wraps onto the next row.
        if (go && rr >= 0 && rr < N && cc >= 0 && cc < N &&
            board_q[2*(rr*N+cc) +: 2] == mover_code) begin
          run_len = run_len + 1;
        end else begin
          go = 1'b0;
        end
      end
    end
  end

  logic       pos_in_range;
  logic [1:0] target_cell;
  logic       move_legal;
  logic       win_now;

  always_comb begin
    pos_in_range = int'(move_pos) < CELLS;
    target_cell  = pos_in_range ? board_q[2*int'(move_pos) +: 2] : CELL_EMPTY;
    move_legal   = pos_in_range && (target_cell == CELL_EMPTY) && (move_player == turn_q);
    win_now      = win_q || (run_len >= K);
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    win_d    = win_q;
    pos_d    = pos_q;

    if (start) begin
      // New game overrides everything, including a CHECK in flight and any offered move.
      state_d  = ST_WAIT;
      board_d  = {CELLS{CELL_EMPTY}};
      turn_d   = first_player;
      count_d  = '0;
      winner_d = CELL_EMPTY;
      draw_d   = 1'b0;
      dir_d    = 2'd0;
      win_d    = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (move_valid) begin
            if (move_legal) begin
              board_d[2*int'(move_pos) +: 2] = move_player ? CELL_A : CELL_B;
              count_d = count_q + CNT_W'(1);
              pos_d   = move_pos;
              dir_d   = 2'd0;
              win_d   = 1'b0;
              state_d = ST_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (dir_q == 2'd3) begin
            ack_d = 1'b1;
            if (win_now) begin
              winner_d = mover_code;
              state_d  = ST_DONE;
            end else if (int'(count_q) == CELLS) begin
              draw_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              turn_d  = ~turn_q;
              state_d = ST_WAIT;
            end
          end else begin
            dir_d = dir_q + 2'd1;
            win_d = win_now;
          end
        end
        default: ;  // IDLE and DONE wait for start
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      board_q  <= {CELLS{CELL_EMPTY}};
      turn_q   <= 1'b1;
      count_q  <= '0;
      winner_q <= CELL_EMPTY;
      draw_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 2'd0;
      win_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      win_q    <= win_d;
      pos_q    <= pos_d;
    end
  end

  assign move_ready = (state_q == ST_WAIT);
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign turn       = turn_q;
  assign board_flat = board_q;
  assign move_count = count_q;
  assign game_over  = (state_q == ST_DONE);
  assign winner     = winner_q;
  assign draw       = draw_q;

endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed bench for mnk_game_engine: a 3x3/K=3 instance and a 5x5/K=4 instance.
module tb_mnk_game_engine;

  logic       clk;
  logic       reset;
  logic       start3, start5;
  logic       first_player;
  logic       move_valid;
  logic [4:0] move_pos;
  logic       move_player;

  logic        ready3, ack3, err3, turn3, over3, draw3;
  logic [17:0] board3;
  logic [3:0]  count3;
  logic [1:0]  winner3;

  logic        ready5, ack5, err5, turn5, over5, draw5;
  logic [49:0] board5;
  logic [4:0]  count5;
  logic [1:0]  winner5;

  int checks = 0;
  int errors = 0;

  mnk_game_engine #(.N(3), .K(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .start        (start3),
    .first_player (first_player),
    .move_valid   (move_valid),
    .move_pos     (move_pos[3:0]),
    .move_player  (move_player),
    .move_ready   (ready3),
    .move_ack     (ack3),
    .move_err     (err3),
    .turn         (turn3),
    .board_flat   (board3),
    .move_count   (count3),
    .game_over    (over3),
    .winner       (winner3),
    .draw         (draw3)
  );

  mnk_game_engine #(.N(5), .K(4)) dut5 (
    .clk          (clk),
    .reset        (reset),
    .start        (start5),
    .first_player (first_player),
    .move_valid   (move_valid),
    .move_pos     (move_pos),
    .move_player  (move_player),
    .move_ready   (ready5),
    .move_ack     (ack5),
    .move_err     (err5),
    .turn         (turn5),
    .board_flat   (board5),
    .move_count   (count5),
    .game_over    (over5),
    .winner       (winner5),
    .draw         (draw5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int sel, input logic fp);
    if (sel == 0) start3 = 1'b1; else start5 = 1'b1;
    first_player = fp;
    @(posedge clk); #1;
    start3 = 1'b0;
    start5 = 1'b0;
  endtask

  // Offer a legal move and check the fixed accept-to-ack latency of four cycles.
  task automatic legal_move(input int sel, input int pos, input logic player);
    move_pos    = 5'(pos);
    move_player = player;
    move_valid  = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("ready_low_after_accept", (sel == 0) ? ready3 : ready5, 1'b0);
    check("cell_written", (sel == 0) ? board3[2*pos +: 2] : board5[2*pos +: 2],
          player ? 2'b01 : 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("ack_not_early", (sel == 0) ? ack3 : ack5, 1'b0);
    @(posedge clk); #1;
    check("ack_at_e4", (sel == 0) ? ack3 : ack5, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    start3       = 1'b0;
    start5       = 1'b0;
    first_player = 1'b1;
    move_valid   = 1'b0;
    move_pos     = '0;
    move_player  = 1'b0;
    #1;
    check("rst_ready", ready3, 1'b0);
    check("rst_board", board3, {9{2'b10}});
    check("rst_turn", turn3, 1'b1);
    check("rst_winner", winner3, 2'b10);
    check("rst_count", count3, 4'd0);
    check("rst_status", {over3, draw3, ack3, err3}, 4'b0000);
    check("rst_board5", board5, {25{2'b10}});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // IDLE ignores moves.
    move_valid = 1'b1; move_pos = 5'd0; move_player = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("idle_board", board3, {9{2'b10}});
    check("idle_err", err3, 1'b0);

    // Row win for A: A0 B3 A1 B4 A2.
    do_start(0, 1'b1);
    check("start_ready", ready3, 1'b1);
    check("start_turn", turn3, 1'b1);
    legal_move(0, 0, 1'b1);
    check("turn_after_a0", turn3, 1'b0);
    check("ready_after_a0", ready3, 1'b1);
    legal_move(0, 3, 1'b0);
    legal_move(0, 1, 1'b1);
    legal_move(0, 4, 1'b0);
    check("no_win_yet", {over3, winner3}, 3'b010);
    legal_move(0, 2, 1'b1);
    check("win_winner", winner3, 2'b01);
    check("win_over", over3, 1'b1);
    check("win_count", count3, 4'd5);
    check("win_ready", ready3, 1'b0);
    check("win_draw", draw3, 1'b0);
    move_valid = 1'b1; move_pos = 5'd5; move_player = 1'b0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("done_no_err", err3, 1'b0);
    check("done_board5", board3[11:10], 2'b10);

    // Rejections.
    do_start(0, 1'b1);
    legal_move(0, 4, 1'b1);
    move_valid = 1'b1; move_pos = 5'd4; move_player = 1'b0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("occupied_err", err3, 1'b1);
    check("occupied_cell", board3[9:8], 2'b01);
    check("occupied_turn", turn3, 1'b0);
    check("occupied_ready", ready3, 1'b1);
    check("occupied_count", count3, 4'd1);
    @(posedge clk); #1;
    check("err_one_cycle", err3, 1'b0);
    move_valid = 1'b1; move_pos = 5'd9; move_player = 1'b0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("range_err", err3, 1'b1);
    move_valid = 1'b1; move_pos = 5'd0; move_player = 1'b1;
    @(posedge clk); #1;
    check("wrong_player_err", err3, 1'b1);
    check("wrong_player_cell", board3[1:0], 2'b10);
    // Corrected move transfers on the very next edge.
    legal_move(0, 0, 1'b0);
    check("corrected_count", count3, 4'd2);

    // Draw: A0 B1 A2 B4 A3 B5 A7 B6 A8.
    do_start(0, 1'b1);
    legal_move(0, 0, 1'b1);
    legal_move(0, 1, 1'b0);
    legal_move(0, 2, 1'b1);
    legal_move(0, 4, 1'b0);
    legal_move(0, 3, 1'b1);
    legal_move(0, 5, 1'b0);
    legal_move(0, 7, 1'b1);
    legal_move(0, 6, 1'b0);
    legal_move(0, 8, 1'b1);
    check("draw_flag", draw3, 1'b1);
    check("draw_winner", winner3, 2'b10);
    check("draw_count", count3, 4'd9);
    check("draw_over", over3, 1'b1);

    // 5x5, K=4: A diagonal 0-6-12-18; B row run 1-2-3 stays below K.
    do_start(1, 1'b1);
    legal_move(1, 0, 1'b1);
    legal_move(1, 1, 1'b0);
    legal_move(1, 6, 1'b1);
    legal_move(1, 2, 1'b0);
    legal_move(1, 12, 1'b1);
    legal_move(1, 3, 1'b0);
    check("n5_no_win", {over5, winner5}, 3'b010);
    legal_move(1, 18, 1'b1);
    check("n5_winner", winner5, 2'b01);
    check("n5_over", over5, 1'b1);
    check("n5_count", count5, 5'd7);

    // start at e2 of a CHECK, with a move offered in the start cycle.
    do_start(0, 1'b1);
    move_valid = 1'b1; move_pos = 5'd0; move_player = 1'b1;
    @(posedge clk); #1;   // e0
    move_valid = 1'b0;
    @(posedge clk); #1;   // e1
    start3 = 1'b1; first_player = 1'b1;
    move_valid = 1'b1; move_pos = 5'd4; move_player = 1'b1;
    @(posedge clk); #1;   // e2
    start3 = 1'b0;
    move_valid = 1'b0;
    check("midchk_board", board3, {9{2'b10}});
    check("midchk_count", count3, 4'd0);
    check("midchk_ack", ack3, 1'b0);
    check("midchk_ready", ready3, 1'b1);
    check("midchk_turn", turn3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midchk_no_late_ack", ack3, 1'b0);
    end
    check("midchk_count_after", count3, 4'd0);

    // B moves first, then reset mid-handshake.
    do_start(0, 1'b0);
    check("fp_b_turn", turn3, 1'b0);
    legal_move(0, 0, 1'b0);
    move_valid = 1'b1; move_pos = 5'd4; move_player = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_ready", ready3, 1'b0);
    check("async_rst_board", board3, {9{2'b10}});
    check("async_rst_count", count3, 4'd0);
    check("async_rst_turn", turn3, 1'b1);
    check("async_rst_winner", winner3, 2'b10);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    move_valid = 1'b0;
    check("post_rst_board", board3, {9{2'b10}});
    check("post_rst_err", err3, 1'b0);
    check("post_rst_ready", ready3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
